// File: rtl/snoop_resp_unit.sv
// Snoop-response engine: round-robin arbitration over N_SNP snoop ports, then per-request
// priority write-back, flag downgrade or invalidate, cache-table flag update and ack.
module snoop_resp_unit #(
    parameter int N_SNP          = 2,
    parameter int NBLK           = 4,
    parameter int CYCLE_NUM_DATA = 2
) (
    input  logic                          plusclk,
    input  logic                          rst,
    input  logic [N_SNP*(2+3*NBLK)-1:0]   snp_vec,
    input  logic                          bus_get,
    output logic                          pwb_req,
    output logic [3:0]                    pwb_clc,
    output logic                          pwb_active,
    output logic [NBLK-1:0]               we_flag_vector,
    output logic [2*NBLK-1:0]             new_flag_vector,
    output logic [N_SNP-1:0]              snp_ack,
    output logic                          snp_error,
    output logic                          snp_busy,
    output logic [2:0]                    st
);

    localparam int SW = 2 + 3*NBLK;
    localparam int PW = (N_SNP > 1) ? $clog2(N_SNP) : 1;
    localparam logic [3:0] CLC = 4'(CYCLE_NUM_DATA);

    localparam logic [1:0] F_INVALID      = 2'd0;
    localparam logic [1:0] F_SHARED_CLEAN = 2'd1;
    localparam logic [1:0] F_OWNED_CLEAN  = 2'd2;
    localparam logic [1:0] F_OWNED_DIRTY  = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EVAL   = 3'd1,
        REQ    = 3'd2,
        XFER   = 3'd3,
        UPDATE = 3'd4
    } state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   rr_ptr, rr_nx, sel, sel_nx, grant_idx;
    logic [1:0]      tgt, tgt_nx;
    logic [3:0]      cnt, cnt_nx;
    logic            found;

    logic [SW-1:0]   slice;
    logic            cur_match, cur_op;
    logic [NBLK-1:0] cur_hit;
    logic [2*NBLK-1:0] cur_flags;
    logic [1:0]      hit_flag;

    assign slice     = snp_vec[int'(sel)*SW +: SW];
    assign cur_match = slice[SW-1];
    assign cur_op    = slice[SW-2];
    assign cur_hit   = slice[3*NBLK-1:2*NBLK];
    assign cur_flags = slice[2*NBLK-1:0];

    // Flag of the hit block; only meaningful once block_hit is known to be one-hot.
    always_comb begin
        hit_flag = 2'd0;
        for (int b = 0; b < NBLK; b++) begin
            if (cur_hit[b]) hit_flag = hit_flag | cur_flags[2*b +: 2];
        end
    end

    // First matching port at or after the round-robin pointer, wrapping.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_SNP; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % N_SNP;
            if (!found && snp_vec[idx*SW + SW-1]) begin
                found     = 1'b1;
                grant_idx = PW'(idx);
            end
        end
    end

    always_ff @(posedge plusclk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            sel    <= '0;
            tgt    <= 2'd0;
            cnt    <= 4'd0;
        end else begin
            state  <= state_nx;
            rr_ptr <= rr_nx;
            sel    <= sel_nx;
            tgt    <= tgt_nx;
            cnt    <= cnt_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        rr_nx           = rr_ptr;
        sel_nx          = sel;
        tgt_nx          = tgt;
        cnt_nx          = cnt;
        pwb_req         = 1'b0;
        pwb_clc         = 4'd0;
        pwb_active      = 1'b0;
        we_flag_vector  = '0;
        new_flag_vector = '0;
        snp_ack         = '0;
        snp_error       = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    sel_nx   = grant_idx;
                    rr_nx    = (int'(grant_idx) == N_SNP-1) ? '0 : grant_idx + PW'(1);
                    state_nx = EVAL;
                end
            end
            EVAL: begin
                if (!cur_match) begin
                    state_nx = IDLE;
                end else if (!$onehot(cur_hit)) begin
                    snp_error    = 1'b1;
                    snp_ack[sel] = 1'b1;
                    state_nx     = IDLE;
                end else begin
                    tgt_nx = cur_op ? F_INVALID : F_SHARED_CLEAN;
                    if (hit_flag == F_OWNED_DIRTY) begin
                        state_nx = REQ;
                    end else if (hit_flag == F_OWNED_CLEAN ||
                                 (cur_op && hit_flag == F_SHARED_CLEAN)) begin
                        state_nx = UPDATE;
                    end else begin
                        snp_ack[sel] = 1'b1;
                        state_nx     = IDLE;
                    end
                end
            end
            REQ: begin
                // Before the bus is granted the requester may still walk away.
                if (!cur_match) begin
                    state_nx = IDLE;
                end else begin
                    pwb_req = 1'b1;
                    pwb_clc = CLC;
                    if (bus_get) begin
                        cnt_nx   = 4'd0;
                        state_nx = XFER;
                    end
                end
            end
            XFER: begin
                pwb_req    = 1'b1;
                pwb_clc    = CLC;
                pwb_active = 1'b1;
                if (cnt == CLC - 4'd1) state_nx = UPDATE;
                else                   cnt_nx   = cnt + 4'd1;
            end
            UPDATE: begin
                // A requester that dropped match during the transfer gets neither write nor ack.
                if (cur_match) begin
                    we_flag_vector = cur_hit;
                    for (int b = 0; b < NBLK; b++) begin
                        if (cur_hit[b]) new_flag_vector[2*b +: 2] = tgt;
                    end
                    snp_ack[sel] = 1'b1;
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign snp_busy = (state != IDLE);
    assign st       = state;

endmodule

// File: tb/tb_snoop_resp_unit.sv
// Bench for snoop_resp_unit: scenario tasks plus a negedge scoreboard that pops the
// expected {ack, we, new_flag, error} word whenever the unit emits a completion.
module tb_snoop_resp_unit;

    localparam int N_SNP = 2;
    localparam int NBLK  = 4;
    localparam int CYC   = 2;
    localparam int SW    = 2 + 3*NBLK;
    localparam int EW    = N_SNP + NBLK + 2*NBLK + 1;

    logic                  clk;
    logic                  rst;
    logic [N_SNP*SW-1:0]   snp_vec;
    logic                  bus_get;
    logic                  pwb_req;
    logic [3:0]            pwb_clc;
    logic                  pwb_active;
    logic [NBLK-1:0]       we_flag_vector;
    logic [2*NBLK-1:0]     new_flag_vector;
    logic [N_SNP-1:0]      snp_ack;
    logic                  snp_error;
    logic                  snp_busy;
    logic [2:0]            st;

    int errors = 0;
    int checks = 0;
    logic saw_pwb;
    logic [EW-1:0] exp_q[$];

    snoop_resp_unit #(.N_SNP(N_SNP), .NBLK(NBLK), .CYCLE_NUM_DATA(CYC)) dut (
        .plusclk(clk), .rst(rst), .snp_vec(snp_vec), .bus_get(bus_get),
        .pwb_req(pwb_req), .pwb_clc(pwb_clc), .pwb_active(pwb_active),
        .we_flag_vector(we_flag_vector), .new_flag_vector(new_flag_vector),
        .snp_ack(snp_ack), .snp_error(snp_error), .snp_busy(snp_busy), .st(st)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [EW-1:0] pack(input logic [N_SNP-1:0] a, input logic [NBLK-1:0] w,
                                           input logic [2*NBLK-1:0] n, input logic e);
        return {a, w, n, e};
    endfunction

    // scoreboard
    always @(negedge clk) begin
        logic [EW-1:0] act, exp_w;
        if (pwb_req) saw_pwb = 1'b1;
        if (snp_ack != '0 || we_flag_vector != '0 || snp_error) begin
            act = pack(snp_ack, we_flag_vector, new_flag_vector, snp_error);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL completion_unexpected: got %b, none expected", act);
            end else begin
                exp_w = exp_q.pop_front();
                if (act !== exp_w) begin
                    errors++;
                    $display("FAIL completion: got {ack,we,nf,err}=%b expected %b", act, exp_w);
                end
            end
        end
    end

    // driver tasks
    task automatic set_slice(input int port, input logic [SW-1:0] v);
        snp_vec[port*SW +: SW] = v;
    endtask

    task automatic apply_reset();
        @(negedge clk); #1;
        rst = 1'b1; snp_vec = '0; bus_get = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_ack(input int port, input logic drop, input int budget, output int lat);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (snp_ack[port]) begin
                lat  = i;
                seen = 1'b1;
                #1;
                if (drop) set_slice(port, '0);
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ack_timeout: port %0d no ack within %0d cycles", port, budget);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (st !== 3'd0 || snp_busy !== 1'b0) begin
            errors++; $display("FAIL reset_state: st=%0d busy=%b expected 0 0", st, snp_busy);
        end
        checks++;
        if (pwb_req !== 1'b0 || pwb_clc !== 4'd0 || pwb_active !== 1'b0) begin
            errors++; $display("FAIL reset_pwb: req=%b clc=%0d act=%b expected 0", pwb_req, pwb_clc, pwb_active);
        end
        checks++;
        if (we_flag_vector !== '0 || new_flag_vector !== '0 || snp_ack !== '0 || snp_error !== 1'b0) begin
            errors++; $display("FAIL reset_flags: we=%b nf=%b ack=%b err=%b expected 0",
                               we_flag_vector, new_flag_vector, snp_ack, snp_error);
        end
    endtask

    task automatic test_pwb(input string name, input int port, input logic [SW-1:0] v,
                            input logic [EW-1:0] exp_w, input int grant_wait);
        int act_cnt, lat;
        @(negedge clk); #1;
        set_slice(port, v);
        exp_q.push_back(exp_w);
        @(negedge clk);
        checks++;
        if (st !== 3'd1 || pwb_req !== 1'b0) begin
            errors++; $display("FAIL %s_eval: st=%0d req=%b expected 1 0", name, st, pwb_req);
        end
        for (int i = 0; i < grant_wait; i++) begin
            @(negedge clk);
            checks++;
            if (pwb_req !== 1'b1 || pwb_clc !== 4'(CYC) || pwb_active !== 1'b0) begin
                errors++; $display("FAIL %s_req: req=%b clc=%0d act=%b expected 1 %0d 0",
                                   name, pwb_req, pwb_clc, pwb_active, CYC);
            end
        end
        #1 bus_get = 1'b1;
        act_cnt = 0;
        lat = 0;
        for (int i = 0; i < 20 && lat == 0; i++) begin
            @(negedge clk);
            if (pwb_active) begin
                act_cnt++;
                checks++;
                if (pwb_req !== 1'b1 || pwb_clc !== 4'(CYC)) begin
                    errors++; $display("FAIL %s_xfer: req=%b clc=%0d expected 1 %0d", name, pwb_req, pwb_clc, CYC);
                end
                #1 bus_get = 1'b0;
            end
            if (snp_ack[port]) begin
                lat = 1;
                #1 set_slice(port, '0);
            end
        end
        checks++;
        if (act_cnt != CYC || lat == 0) begin
            errors++; $display("FAIL %s_active: active cycles=%0d ack=%0d expected %0d 1", name, act_cnt, lat, CYC);
        end
        bus_get = 1'b0;
    endtask

    task automatic test_flag_only();
        int lat;
        @(negedge clk); #1;
        saw_pwb = 1'b0;
        set_slice(1, 14'b10_0100_0010_0000);
        exp_q.push_back(pack(2'b10, 4'b0100, 8'b0001_0000, 1'b0));
        wait_ack(1, 1'b1, 10, lat);
        checks++;
        // EVAL then UPDATE: ack seen on the second negedge after match is driven
        if (lat != 2 || saw_pwb !== 1'b0) begin
            errors++; $display("FAIL flag_only_latency: lat=%0d pwb_seen=%b expected 2 0", lat, saw_pwb);
        end
    endtask

    task automatic test_error();
        int lat;
        @(negedge clk); #1;
        set_slice(0, 14'b10_0011_0000_0101);
        exp_q.push_back(pack(2'b01, 4'b0000, 8'b0, 1'b1));
        wait_ack(0, 1'b1, 10, lat);
        checks++;
        if (lat != 1) begin
            errors++; $display("FAIL error_latency: lat=%0d expected 1", lat);
        end
        @(negedge clk); #1;
        set_slice(1, 14'b10_0000_0000_0011);
        exp_q.push_back(pack(2'b10, 4'b0000, 8'b0, 1'b1));
        wait_ack(1, 1'b1, 10, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        apply_reset();
        @(negedge clk); #1;
        set_slice(0, 14'b10_0001_0000_0001);
        set_slice(1, 14'b10_0010_0000_0100);
        exp_q.push_back(pack(2'b01, 4'b0, 8'b0, 1'b0));
        exp_q.push_back(pack(2'b10, 4'b0, 8'b0, 1'b0));
        wait_ack(0, 1'b1, 10, lat);
        wait_ack(1, 1'b1, 10, lat);
        // pointer back at 0; port0 keeps holding after its ack, port1 must still get its turn
        @(negedge clk); #1;
        set_slice(0, 14'b10_0001_0000_0001);
        set_slice(1, 14'b10_0010_0000_0100);
        exp_q.push_back(pack(2'b01, 4'b0, 8'b0, 1'b0));
        exp_q.push_back(pack(2'b10, 4'b0, 8'b0, 1'b0));
        exp_q.push_back(pack(2'b01, 4'b0, 8'b0, 1'b0));
        wait_ack(0, 1'b0, 10, lat);
        wait_ack(1, 1'b1, 10, lat);
        wait_ack(0, 1'b1, 10, lat);
    endtask

    task automatic test_abandon();
        @(negedge clk); #1;
        set_slice(0, 14'b10_0001_0000_0011);
        repeat (2) @(negedge clk);
        #1 set_slice(0, '0);
        @(negedge clk);
        checks++;
        if (st !== 3'd0 || pwb_req !== 1'b0) begin
            errors++; $display("FAIL abandon: st=%0d req=%b expected 0 0", st, pwb_req);
        end
    endtask

    task automatic test_rst_xfer();
        @(negedge clk); #1;
        set_slice(0, 14'b10_0001_0000_0011);
        @(negedge clk);
        @(negedge clk); #1 bus_get = 1'b1;
        @(negedge clk);
        checks++;
        if (st !== 3'd3 || pwb_active !== 1'b1) begin
            errors++; $display("FAIL rst_reach_xfer: st=%0d act=%b expected 3 1", st, pwb_active);
        end
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (st !== 3'd0 || pwb_req !== 1'b0 || pwb_active !== 1'b0 || snp_ack !== '0 || we_flag_vector !== '0) begin
            errors++; $display("FAIL rst_xfer: st=%0d req=%b act=%b ack=%b we=%b expected all 0",
                               st, pwb_req, pwb_active, snp_ack, we_flag_vector);
        end
        #1;
        rst = 1'b0; snp_vec = '0; bus_get = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (st !== 3'd0 || snp_busy !== 1'b0) begin
            errors++; $display("FAIL rst_after: st=%0d busy=%b expected 0 0", st, snp_busy);
        end
    endtask

    initial begin
        rst = 1'b1; snp_vec = '0; bus_get = 1'b0; saw_pwb = 1'b0;
        test_reset();
        test_pwb("pwb_rd", 0, 14'b10_0001_0000_0011, pack(2'b01, 4'b0001, 8'b0000_0001, 1'b0), 3);
        test_flag_only();
        test_pwb("pwb_wr", 0, 14'b11_0010_0000_1100, pack(2'b01, 4'b0010, 8'b0000_0000, 1'b0), 3);
        test_pwb("pwb_p1", 1, 14'b11_1000_1100_0000, pack(2'b10, 4'b1000, 8'b0000_0000, 1'b0), $urandom_range(0, 4));
        test_back_to_back();
        test_error();
        test_abandon();
        test_rst_xfer();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d completions outstanding, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
